mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between instruction fetch and data ports.
// Issue/wait FSM with data-first priority and a starvation guard for IF.
module mem_port_arbiter #(
    parameter int LATENCY    = 2,
    parameter int STARVE_MAX = 4,
    parameter int AW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [31:0]   if_rdata,
    output logic          if_valid,
    output logic          if_stall,
    input  logic          d_req,
    input  logic [3:0]    d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic [31:0]   d_rdata,
    output logic          d_valid,
    output logic          d_stall,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);
    localparam int CW = $clog2(LATENCY + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [SW-1:0] starve;
    logic          owner_if;
    logic [3:0]    we_q;
    logic          if_elig, d_elig, grant_if, grant_d;

    // A port is ineligible in its own valid cycle so a held req is not served twice.
    assign if_elig  = if_req & ~if_valid;
    assign d_elig   = d_req & ~d_valid;
    assign grant_if = (state == IDLE) & if_elig & ((starve == SW'(STARVE_MAX)) | ~d_elig);
    assign grant_d  = (state == IDLE) & d_elig & ~grant_if;

    assign if_stall = if_req & ~if_valid;
    assign d_stall  = d_req & ~d_valid;

    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_if || grant_d) state_nxt = ISSUE;
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == CW'(1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            starve    <= '0;
            owner_if  <= 1'b0;
            we_q      <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
        end else begin
            state    <= state_nxt;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;

            if (grant_if) begin
                owner_if <= 1'b1;
                mem_addr <= if_addr;
                we_q     <= 4'b0000;
                starve   <= '0;
            end else if (grant_d) begin
                owner_if  <= 1'b0;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                we_q      <= d_we;
                if (!if_req)
                    starve <= '0;
                else if (starve != SW'(STARVE_MAX))
                    starve <= starve + 1'b1;
            end

            if (state == ISSUE) begin
                cnt <= CW'(LATENCY);
            end else if (state == WAIT) begin
                cnt <= cnt - 1'b1;
                // mem_rdata is valid in the last wait cycle; writes leave d_rdata untouched.
                if (cnt == CW'(1)) begin
                    if (owner_if) begin
                        if_valid <= 1'b1;
                        if_rdata <= mem_rdata;
                    end else begin
                        d_valid <= 1'b1;
                        if (we_q == 4'b0000) d_rdata <= mem_rdata;
                    end
                end
            end
        end
    end
endmodule
